frame_scanout: RTL
==================

// Module: frame_scanout
// PURPOSE
//   Read side of the 640x480 frame buffer: sweeps VGA raster timing, issues one
//   pixel read per clock for visible pixels, and realigns the returned data with
//   hsync/vsync/blank so they drive the DAC. Frame-buffer writers (screen clear,
//   drawing) fill the buffer; this block drains it every frame at the pixel clock.
// PARAMETERS
//   H_ACTIVE 640  visible pixels per line     H_FP 16  H_SYNC 96  H_BP 48 (pixels)
//   V_ACTIVE 480  visible lines per frame     V_FP 10  V_SYNC 2   V_BP 33 (lines)
//   RD_LAT   2    clk cycles from rd_req to rd_data valid (>=1)
//   COLOR_W  8    pixel data width
// PORTS
//   clk          in   1        pixel clock; all logic on posedge
//   reset_n      in   1        asynchronous, active-low reset
//   enable       in   1        1 = scan frames; 0 = hold at raster origin, blanked
//   rd_req       out  1        read strobe, high for visible (x,y) only
//   rd_x         out  11       read column 0..H_ACTIVE-1
//   rd_y         out  11       read row    0..V_ACTIVE-1
//   rd_data      in   COLOR_W  buffer data, valid RD_LAT cycles after rd_req
//   pixel        out  COLOR_W  display data; 0 whenever blank_n=0
//   hsync_n      out  1        horizontal sync, active low
//   vsync_n      out  1        vertical sync, active low
//   blank_n      out  1        1 = visible pixel on outputs
//   frame_start  out  1        1-cycle pulse with output pixel (0,0)
// BEHAVIOUR
//   - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//   - h_cnt 0..H_TOTAL-1 increments each cycle while enable; at H_TOTAL-1 wraps
//     to 0 and v_cnt increments; v_cnt at V_TOTAL-1 with h wrap goes to 0.
//   - Stage 0 (combinational from counters): vis = h<H_ACTIVE && v<V_ACTIVE;
//     rd_req=vis&&enable, rd_x=vis?h:0, rd_y=vis?v:0;
//     hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs = v in
//     [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); fs = (h==0 && v==0 && enable).
//   - vis/hs/vs/fs pass through an RD_LAT-deep register pipeline; outputs:
//     blank_n=vis_d, hsync_n=~hs_d, vsync_n=~vs_d, frame_start=fs_d,
//     pixel = vis_d ? rd_data : 0 (combinational mux, no extra stage).
//   - Total latency counter->outputs = RD_LAT cycles; syncs and data aligned.
//   - reset_n=0 (async): h_cnt=v_cnt=0, all pipeline stages cleared
//     (vis=0, hs=0, vs=0, fs=0) -> rd_req=0, rd_x=rd_y=0, pixel=0, blank_n=0,
//     hsync_n=1, vsync_n=1, frame_start=0. Release: first enabled cycle is (0,0).
//   - enable=0 (sync, any point mid-frame): next edge h_cnt=v_cnt=0 and pipeline
//     cleared (same values as reset); rd_req=0 immediately (combinational gate).
//     enable re-asserted: scan restarts at (0,0); frame_start RD_LAT cycles later.
//   - No backpressure: rd_data is sampled unconditionally; buffer must meet RD_LAT.
//   - Counters 11 bits; compares use full H_TOTAL/V_TOTAL values, no truncation.
// TESTING
//   1 reset_n=0 with enable=1 -> all outputs at reset values; release -> rd_req=1,
//     rd_x=0, rd_y=0 same cycle; frame_start=1 exactly 2 cycles later.
//   2 Model returns rd_data={x[3:0],y[3:0]} after 2 cycles -> each blank_n=1
//     cycle pixel equals that pattern for the (x,y) issued 2 cycles earlier;
//     rd_req count per frame = 307200.
//   3 Line timing: hsync_n low for 96 cycles starting 656 cycles after line's
//     first pixel; line period 800; blank_n high 640 per line.
//   4 Frame timing: vsync_n low lines 490..491 (1600 cycles); frame_start period
//     420000 cycles; after v=524,h=799 next rd_x=0,rd_y=0.
//   5 Drop enable at (h=300,v=200) for 3 cycles -> rd_req=0 at once, outputs at
//     reset values within 2 cycles; on re-enable rd_x=0,rd_y=0, frame_start +2.
//   6 RD_LAT=1 and RD_LAT=4 builds -> pixel/blank_n/syncs shifted by RD_LAT, pass 2-4.

Source files
------------

// File: rtl/frame_scanout_if.sv
// Frame-buffer read port plus the DAC-facing video outputs of the scanout block.
// The master side (frame_scanout) issues reads and drives the video signals;
// the slave side returns read data and consumes the video stream.
interface frame_scanout_if #(
  parameter int COLOR_W = 8
);
  logic               rd_req;
  logic [10:0]        rd_x;
  logic [10:0]        rd_y;
  logic [COLOR_W-1:0] rd_data;
  logic [COLOR_W-1:0] pixel;
  logic               hsync_n;
  logic               vsync_n;
  logic               blank_n;
  logic               frame_start;

  modport master (
    output rd_req, rd_x, rd_y, pixel, hsync_n, vsync_n, blank_n, frame_start,
    input  rd_data
  );

  modport slave (
    input  rd_req, rd_x, rd_y, pixel, hsync_n, vsync_n, blank_n, frame_start,
    output rd_data
  );
endinterface

// File: rtl/frame_scanout.sv
// Read side of the frame buffer: sweeps VGA raster timing, issues one read per
// visible pixel and delays blank/sync/frame-start by the buffer read latency so
// they line up with the returned pixel data at the DAC.
module frame_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 2,
  parameter int COLOR_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  frame_scanout_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hCnt_q, hCnt_d;
  logic [10:0] vCnt_q, vCnt_d;

  logic vis, hs, vs, fs;

  logic [RD_LAT-1:0] visPipe_q;
  logic [RD_LAT-1:0] hsPipe_q;
  logic [RD_LAT-1:0] vsPipe_q;
  logic [RD_LAT-1:0] fsPipe_q;

  logic               visOut;
  logic [COLOR_W-1:0] pixelOut;

  // Raster position advance: dropping enable parks the scan at the origin.
  always_comb begin
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (!enable) begin
      hCnt_d = '0;
      vCnt_d = '0;
    end else if (hCnt_q == H_LAST) begin
      hCnt_d = '0;
      vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 11'd1;
    end else begin
      hCnt_d = hCnt_q + 11'd1;
    end
  end

  // Raster counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else begin
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

  // Stage 0 decode straight off the counters. The read strobe is also gated by
  // reset so no read goes out while the counters are being held at the origin.
  assign vis = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
  assign hs  = (hCnt_q >= HS_START) && (hCnt_q < HS_END);
  assign vs  = (vCnt_q >= VS_START) && (vCnt_q < VS_END);
  assign fs  = (hCnt_q == '0) && (vCnt_q == '0) && enable;

  assign bus.rd_req = vis && enable && reset_n;
  assign bus.rd_x   = vis ? hCnt_q : '0;
  assign bus.rd_y   = vis ? vCnt_q : '0;

  // Delay line matching the buffer read latency; flushed whenever scanning stops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      visPipe_q <= '0;
      hsPipe_q  <= '0;
      vsPipe_q  <= '0;
      fsPipe_q  <= '0;
    end else if (!enable) begin
      visPipe_q <= '0;
      hsPipe_q  <= '0;
      vsPipe_q  <= '0;
      fsPipe_q  <= '0;
    end else begin
      visPipe_q[0] <= vis;
      hsPipe_q[0]  <= hs;
      vsPipe_q[0]  <= vs;
      fsPipe_q[0]  <= fs;
      for (int i = 1; i < RD_LAT; i++) begin
        visPipe_q[i] <= visPipe_q[i-1];
        hsPipe_q[i]  <= hsPipe_q[i-1];
        vsPipe_q[i]  <= vsPipe_q[i-1];
        fsPipe_q[i]  <= fsPipe_q[i-1];
      end
    end
  end

  // Output side: read data is only shown during the visible window.
  assign visOut   = visPipe_q[RD_LAT-1];
  assign pixelOut = visOut ? bus.rd_data : '0;

  assign bus.pixel       = pixelOut;
  assign bus.blank_n     = visOut;
  assign bus.hsync_n     = ~hsPipe_q[RD_LAT-1];
  assign bus.vsync_n     = ~vsPipe_q[RD_LAT-1];
  assign bus.frame_start = fsPipe_q[RD_LAT-1];

endmodule
